pin_attempt_ctrl: RTL and testbench
===================================

Name: pin_attempt_ctrl

Overview:
- Sequencer between the 2-bit keypad front end and the PIN checker datapath.
- Paces digit submissions to the checker's 3-cycle load rate and clears the checker between attempts.
- Collects the checker's correct/incorrect verdict, counts consecutive failures, and enforces a timed lockout after MAX_TRIES failures.
- Drives the top-level unlocked/locked indicators.

Parameters:
- MAX_TRIES, 3, consecutive failures that trigger lockout (1..7).
- LOCK_CYCLES, 1000, lockout duration in clk cycles.
- UNLOCK_CYCLES, 500, cycles `unlocked` is held after a correct PIN.
- IDLE_TIMEOUT, 2000, cycles without a key press before a partial entry is abandoned.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle key press strobe
- key_digit  in  2  digit value, qualified by key_valid
- key_ready  out  1  high when a press will be accepted
- chk_submit  out  1  registered submit strobe to the checker
- chk_digit  out  2  registered digit to the checker
- chk_reset  out  1  active-high synchronous reset to the checker
- chk_waiting  in  1  checker idle/waiting flag
- chk_correct  in  1  checker verdict: correct
- chk_incorrect  in  1  checker verdict: incorrect
- unlocked  out  1  access granted
- locked_out  out  1  lockout active
- fail_count  out  3  consecutive failure count
- err  out  1  one-cycle protocol error pulse

Behaviour:
- Reset (reset_n=0, async):
  - state=CLR with its cycle count restarted; all counters=0.
  - Outputs: chk_reset=1; key_ready, chk_submit, chk_digit, unlocked, locked_out, err=0; fail_count=0.
- States: CLR, IDLE, ENTRY, WAIT_RES, PASS, FAIL, LOCK.
- CLR:
  - chk_reset=1 for exactly 2 cycles, then IDLE.
  - CLR is entered from reset, abort, PASS end, FAIL (no lock) and LOCK end.
- IDLE:
  - Waits for chk_waiting=1, then ENTRY.
  - key_ready=0 and key presses are ignored.
- ENTRY:
  - key_ready=1 unless fewer than 3 cycles have elapsed since the last accepted key.
  - Accept = key_valid & key_ready. The next cycle drives chk_submit=1 and chk_digit=key_digit for exactly 1 cycle.
  - key_valid while key_ready=0 is dropped silently, with no count change.
  - 2-bit digit counter increments per accept. On the 4th accept, go to WAIT_RES on the same edge the 4th chk_submit is registered.
  - Idle counter resets on every accept. If at least 1 digit is accepted and the counter reaches IDLE_TIMEOUT, go to CLR (abort): fail_count unchanged, no err.
- WAIT_RES:
  - Samples chk_correct/chk_incorrect every cycle.
  - correct=1 and incorrect=0 → PASS.
  - incorrect=1 and correct=0 → FAIL.
  - Both high → err pulse, treated as FAIL.
- PASS:
  - fail_count←0; unlocked=1 for UNLOCK_CYCLES cycles, then CLR with unlocked←0.
- FAIL:
  - 1 cycle; fail_count←fail_count+1, saturating at MAX_TRIES.
  - If the new value equals MAX_TRIES → LOCK, else → CLR.
- LOCK:
  - locked_out=1, chk_reset=1 (checker held); key_ready=0.
  - After LOCK_CYCLES cycles: fail_count←0, locked_out←0, go to CLR.
- Counters: sized $clog2 of their parameter plus 1. Terminal compare is ==.
- Unexpected state encoding → CLR with err pulse.

Optional Feature:
- Macro PIN_CTRL_WATCHDOG_EN.
- Defined: WAIT_RES has a 64-cycle watchdog. If no verdict arrives by cycle 64, pulse err and go to CLR, with fail_count unchanged.
- Undefined: WAIT_RES waits indefinitely. No watchdog logic is synthesized.

Test Plan (override MAX_TRIES=3, LOCK_CYCLES=16, UNLOCK_CYCLES=8, IDLE_TIMEOUT=32; checker model with passkey 2,2,1,1):
- Reset, then keys 2,2,1,1 spaced 4 cycles → exactly 4 chk_submit pulses carrying 2,2,1,1; PASS; unlocked=1 for 8 cycles; fail_count=0; then chk_reset high for 2 cycles.
- Three wrong PINs (0,0,0,0) → fail_count steps 1,2,3; after the 3rd, locked_out=1 for 16 cycles with key_ready=0; afterwards fail_count=0 and locked_out=0.
- Keys presented on back-to-back cycles → only every 3rd-cycle press is forwarded; dropped presses produce no chk_submit and no digit count change.
- Two digits entered, then no input for 32 cycles → CLR abort; fail_count unchanged; err=0; next full entry is accepted normally.
- Checker model asserts chk_correct and chk_incorrect together → err pulses for 1 cycle; fail_count+1.
- Reset_n asserted mid-ENTRY and mid-LOCK → all outputs reach reset values immediately (chk_reset=1); first key after release requires IDLE→ENTRY.

Source files
------------

// File: rtl/pin_attempt_ctrl.sv
// pin_attempt_ctrl: paces keypad digits into the PIN checker, collects its verdict,
// counts consecutive failures and enforces a timed lockout. Define PIN_CTRL_WATCHDOG_EN for a WAIT_RES watchdog.
module pin_attempt_ctrl #(
  parameter int MAX_TRIES     = 3,
  parameter int LOCK_CYCLES   = 1000,
  parameter int UNLOCK_CYCLES = 500,
  parameter int IDLE_TIMEOUT  = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [1:0] key_digit,
  output logic       key_ready,
  output logic       chk_submit,
  output logic [1:0] chk_digit,
  output logic       chk_reset,
  input  logic       chk_waiting,
  input  logic       chk_correct,
  input  logic       chk_incorrect,
  output logic       unlocked,
  output logic       locked_out,
  output logic [2:0] fail_count,
  output logic       err
);

  localparam int MAX_A = (LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES;
  localparam int MAX_B = (MAX_A > IDLE_TIMEOUT) ? MAX_A : IDLE_TIMEOUT;
  localparam int MAX_P = (MAX_B > 64) ? MAX_B : 64;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] CLR_LAST    = CW'(1);
  localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LIMIT  = CW'(IDLE_TIMEOUT);
  localparam logic [2:0]    MAX_FC      = 3'(MAX_TRIES);
`ifdef PIN_CTRL_WATCHDOG_EN
  localparam logic [CW-1:0] WDOG_LAST   = CW'(63);
`endif

  typedef enum logic [2:0] {
    S_CLR,
    S_IDLE,
    S_ENTRY,
    S_WAIT_RES,
    S_PASS,
    S_FAIL,
    S_LOCK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    gap_q, gap_d;
  logic [1:0]    dig_q, dig_d;
  logic [2:0]    fail_q, fail_d;
  logic [2:0]    fail_next;
  logic          submit_q, submit_d;
  logic [1:0]    digit_q, digit_d;
  logic          err_q, err_d;
  logic          accept;

  // gap_q counts down the two blocked cycles that follow each accepted key
  assign key_ready = (state_q == S_ENTRY) && (gap_q == 2'd0);
  assign accept    = key_ready && key_valid;

  assign chk_submit = submit_q;
  assign chk_digit  = digit_q;
  assign chk_reset  = (state_q == S_CLR) || (state_q == S_LOCK);
  assign unlocked   = (state_q == S_PASS);
  assign locked_out = (state_q == S_LOCK);
  assign fail_count = fail_q;
  assign err        = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    gap_d     = gap_q;
    dig_d     = dig_q;
    fail_d    = fail_q;
    fail_next = fail_q;
    submit_d  = 1'b0;
    digit_d   = digit_q;
    err_d     = 1'b0;

    case (state_q)
      S_CLR: begin
        gap_d = 2'd0;
        dig_d = 2'd0;
        if (cnt_q == CLR_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (chk_waiting) state_d = S_ENTRY;
      end
      S_ENTRY: begin
        if (gap_q != 2'd0) gap_d = gap_q - 2'd1;
        if (accept) begin
          submit_d = 1'b1;
          digit_d  = key_digit;
          gap_d    = 2'd2;
          dig_d    = dig_q + 2'd1;
          cnt_d    = '0;
          if (dig_q == 2'd3) state_d = S_WAIT_RES;
        end else if (dig_q == 2'd0) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LIMIT) begin
          state_d = S_CLR;
        end
      end
      S_WAIT_RES: begin
        if (chk_correct && chk_incorrect) begin
          err_d   = 1'b1;
          state_d = S_FAIL;
        end else if (chk_correct) begin
          fail_d  = 3'd0;
          state_d = S_PASS;
        end else if (chk_incorrect) begin
          state_d = S_FAIL;
        end
`ifdef PIN_CTRL_WATCHDOG_EN
        else if (cnt_q == WDOG_LAST) begin
          err_d   = 1'b1;
          state_d = S_CLR;
        end
`else
        cnt_d = '0;
`endif
      end
      S_PASS: begin
        if (cnt_q == UNLOCK_LAST) state_d = S_CLR;
      end
      S_FAIL: begin
        fail_next = (fail_q >= MAX_FC) ? MAX_FC : fail_q + 3'd1;
        fail_d    = fail_next;
        state_d   = (fail_next == MAX_FC) ? S_LOCK : S_CLR;
      end
      S_LOCK: begin
        if (cnt_q == LOCK_LAST) begin
          fail_d  = 3'd0;
          state_d = S_CLR;
        end
      end
      default: begin
        err_d   = 1'b1;
        state_d = S_CLR;
      end
    endcase

    // every state's cycle count starts from zero on entry
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_CLR;
      cnt_q    <= '0;
      gap_q    <= 2'd0;
      dig_q    <= 2'd0;
      fail_q   <= 3'd0;
      submit_q <= 1'b0;
      digit_q  <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      dig_q    <= dig_d;
      fail_q   <= fail_d;
      submit_q <= submit_d;
      digit_q  <= digit_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_pin_attempt_ctrl.sv
// tb_pin_attempt_ctrl: randomized self-checking bench for pin_attempt_ctrl with a
// behavioural checker (passkey 2,2,1,1) and a timing-rule reference model.
module tb_pin_attempt_ctrl;

  localparam int MAXT  = 3;
  localparam int LOCKC = 16;
  localparam int UNLC  = 8;
  localparam int IDLET = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       key_valid = 1'b0;
  logic [1:0] key_digit = 2'd0;
  logic       chk_waiting = 1'b0;
  logic       chk_correct = 1'b0;
  logic       chk_incorrect = 1'b0;
  logic       key_ready;
  logic       chk_submit;
  logic [1:0] chk_digit;
  logic       chk_reset;
  logic       unlocked;
  logic       locked_out;
  logic [2:0] fail_count;
  logic       err;

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;
  int err_pulses = 0;
  bit force_both = 1'b0;
  bit model_ok;
  logic [1:0] sub_q [$];
  logic [1:0] cd [$];
  logic [1:0] passkey [4] = '{2'd2, 2'd2, 2'd1, 2'd1};

  pin_attempt_ctrl #(
    .MAX_TRIES    (MAXT),
    .LOCK_CYCLES  (LOCKC),
    .UNLOCK_CYCLES(UNLC),
    .IDLE_TIMEOUT (IDLET)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .key_ready    (key_ready),
    .chk_submit   (chk_submit),
    .chk_digit    (chk_digit),
    .chk_reset    (chk_reset),
    .chk_waiting  (chk_waiting),
    .chk_correct  (chk_correct),
    .chk_incorrect(chk_incorrect),
    .unlocked     (unlocked),
    .locked_out   (locked_out),
    .fail_count   (fail_count),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Observe forwarded digits and error pulses mid-cycle
  always @(negedge clk) begin
    if (reset_n && chk_submit) sub_q.push_back(chk_digit);
    if (reset_n && err) err_pulses++;
  end

  // Checker model: collects four digits, then holds a verdict until cleared
  always @(negedge clk) begin
    if (!reset_n || chk_reset) begin
      cd.delete();
      chk_correct   = 1'b0;
      chk_incorrect = 1'b0;
      chk_waiting   = 1'b0;
    end else begin
      if (chk_submit) cd.push_back(chk_digit);
      if (cd.size() == 4 && !chk_correct && !chk_incorrect) begin
        if (force_both) begin
          chk_correct   = 1'b1;
          chk_incorrect = 1'b1;
          force_both    = 1'b0;
        end else begin
          model_ok = 1'b1;
          for (int i = 0; i < 4; i++) if (cd[i] != passkey[i]) model_ok = 1'b0;
          chk_correct   = model_ok;
          chk_incorrect = !model_ok;
        end
      end
      chk_waiting = (cd.size() == 0);
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got no finish, required finish before time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_async_reset(input string where);
    reset_n = 1'b0;
    #1;
    checks++;
    if (chk_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_chk_reset: got %b required 1", where, chk_reset);
    end
    checks++;
    if ({key_ready, chk_submit, chk_digit, unlocked, locked_out, fail_count, err} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL %s_outputs: got %b required 0000000000", where,
               {key_ready, chk_submit, chk_digit, unlocked, locked_out, fail_count, err});
    end
    exp_fc = 0;
    tick();
    tick();
    reset_n = 1'b1;
    checks++;
    if (key_ready !== 1'b0 || chk_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_post_release: got ready=%b chk_reset=%b required ready=0 chk_reset=1",
               where, key_ready, chk_reset);
    end
  endtask

  task automatic wait_entry();
    int n = 0;
    while (chk_reset === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("[TB] FAIL clr_stuck: got chk_reset=%b after %0d cycles required 0", chk_reset, n);
    end
    checks++;
    if (key_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_key_ready: got %b required 0", key_ready);
    end
    key_valid = 1'b1;
    key_digit = 2'($urandom_range(0, 3));
    tick();
    key_valid = 1'b0;
  endtask

  // mode 0 random, 1 passkey spaced 4, 2 zeros spaced 4, 3 press every cycle
  task automatic enter_presses(input int mode, output bit exp_pass);
    int k = 0;
    int la = -100;
    int acc = 0;
    bit press;
    bit ready_exp;
    logic [1:0] dg;
    logic [1:0] dq [$];
    sub_q.delete();
    while (acc < 4 && k < 100) begin
      ready_exp = ((k - la) >= 3);
      checks++;
      if (key_ready !== ready_exp) begin
        errors++;
        $display("[TB] FAIL key_ready_k%0d: got %b required %b", k, key_ready, ready_exp);
      end
      case (mode)
        1:       begin press = (k % 4 == 0); dg = passkey[acc]; end
        2:       begin press = (k % 4 == 0); dg = 2'd0; end
        3:       begin press = 1'b1; dg = 2'($urandom_range(0, 3)); end
        default: begin
          press = ($urandom_range(0, 2) != 0);
          dg = ($urandom_range(0, 2) != 0) ? passkey[acc] : 2'($urandom_range(0, 3));
        end
      endcase
      key_valid = press;
      key_digit = dg;
      if (press && ready_exp) begin
        acc++;
        la = k;
        dq.push_back(dg);
      end
      tick();
      k++;
    end
    key_valid = 1'b0;
    tick();
    checks++;
    if (sub_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL submit_count: got %0d required 4", sub_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (sub_q[i] !== dq[i]) begin
          errors++;
          $display("[TB] FAIL submit_digit%0d: got %0d required %0d", i, sub_q[i], dq[i]);
        end
      end
    end
    exp_pass = 1'b1;
    for (int i = 0; i < 4; i++) if (dq[i] != passkey[i]) exp_pass = 1'b0;
  endtask

  task automatic handle_verdict(input bit exp_pass, input bit both, input int err_before);
    int n = 0;
    while (!(unlocked === 1'b1 || chk_reset === 1'b1) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("[TB] FAIL verdict_timeout: got no verdict in %0d cycles required one", n);
      return;
    end
    if (exp_pass && !both) begin
      checks++;
      if (unlocked !== 1'b1 || fail_count !== 3'd0) begin
        errors++;
        $display("[TB] FAIL pass_state: got unlocked=%b fail_count=%0d required 1,0", unlocked, fail_count);
      end
      n = 0;
      while (unlocked === 1'b1 && n < 40) begin
        n++;
        tick();
      end
      checks++;
      if (n !== UNLC) begin
        errors++;
        $display("[TB] FAIL unlock_len: got %0d required %0d", n, UNLC);
      end
      n = 0;
      while (chk_reset === 1'b1 && n < 10) begin
        n++;
        tick();
      end
      checks++;
      if (n !== 2) begin
        errors++;
        $display("[TB] FAIL clr_len: got %0d required 2", n);
      end
      exp_fc = 0;
    end else begin
      exp_fc = (exp_fc >= MAXT) ? MAXT : exp_fc + 1;
      checks++;
      if (unlocked !== 1'b0 || fail_count !== 3'(exp_fc)) begin
        errors++;
        $display("[TB] FAIL fail_step: got unlocked=%b fail_count=%0d required 0,%0d", unlocked, fail_count, exp_fc);
      end
      checks++;
      if (locked_out !== (exp_fc == MAXT)) begin
        errors++;
        $display("[TB] FAIL lock_entry: got %b required %b", locked_out, (exp_fc == MAXT));
      end
      if (exp_fc == MAXT) begin
        n = 0;
        while (locked_out === 1'b1 && n < 40) begin
          checks++;
          if (key_ready !== 1'b0 || chk_reset !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_hold: got ready=%b chk_reset=%b required 0,1", key_ready, chk_reset);
          end
          n++;
          tick();
        end
        checks++;
        if (n !== LOCKC) begin
          errors++;
          $display("[TB] FAIL lock_len: got %0d required %0d", n, LOCKC);
        end
        checks++;
        if (fail_count !== 3'd0) begin
          errors++;
          $display("[TB] FAIL lock_release_fc: got %0d required 0", fail_count);
        end
        exp_fc = 0;
      end
    end
    checks++;
    if ((err_pulses - err_before) !== (both ? 1 : 0)) begin
      errors++;
      $display("[TB] FAIL err_pulses: got %0d required %0d", err_pulses - err_before, both ? 1 : 0);
    end
  endtask

  task automatic run_attempt(input int mode, input bit both);
    bit exp_pass;
    int eb;
    wait_entry();
    eb = err_pulses;
    force_both = both;
    enter_presses(mode, exp_pass);
    handle_verdict(exp_pass, both, eb);
  endtask

  task automatic test_reset();
    #3;
    apply_async_reset("reset");
  endtask

  task automatic test_pass();
    run_attempt(1, 1'b0);
  endtask

  task automatic test_lockout();
    for (int i = 0; i < MAXT; i++) run_attempt(2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_attempt(3, 1'b0);
  endtask

  task automatic test_idle_abort();
    int n;
    int eb;
    run_attempt(2, 1'b0);
    wait_entry();
    eb = err_pulses;
    sub_q.delete();
    key_valid = 1'b1;
    key_digit = 2'd2;
    tick();
    key_valid = 1'b0;
    tick();
    tick();
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    n = 1;
    while (chk_reset !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n < IDLET || n > IDLET + 3) begin
      errors++;
      $display("[TB] FAIL abort_delay: got %0d cycles required %0d..%0d", n, IDLET, IDLET + 3);
    end
    checks++;
    if (sub_q.size() != 2 || fail_count !== 3'(exp_fc) || (err_pulses - eb) != 0) begin
      errors++;
      $display("[TB] FAIL abort_state: got submits=%0d fc=%0d errs=%0d required 2,%0d,0",
               sub_q.size(), fail_count, err_pulses - eb, exp_fc);
    end
    run_attempt(1, 1'b0);
  endtask

  task automatic test_both_verdicts();
    run_attempt(2, 1'b1);
    run_attempt(1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) run_attempt(0, ($urandom_range(0, 4) == 0));
  endtask

  task automatic test_reset_mid_entry();
    run_attempt(2, 1'b0);
    wait_entry();
    key_valid = 1'b1;
    key_digit = 2'd1;
    tick();
    key_valid = 1'b0;
    tick();
    #2;
    apply_async_reset("mid_entry");
    run_attempt(1, 1'b0);
  endtask

  task automatic test_reset_mid_lock();
    bit exp_pass;
    int n = 0;
    while (exp_fc < MAXT - 1) run_attempt(2, 1'b0);
    wait_entry();
    enter_presses(2, exp_pass);
    while (chk_reset !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (locked_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lock_before_reset: got %b required 1", locked_out);
    end
    for (int i = 0; i < 5; i++) tick();
    #2;
    apply_async_reset("mid_lock");
    run_attempt(1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_lockout();
    test_back_to_back();
    test_idle_abort();
    test_both_verdicts();
    test_random();
    test_reset_mid_entry();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
